pmu_counter_bank: RTL and testbench

- Event-counter bank that sits directly upstream of the PMU AXI4-Lite slave.
- Counts single-cycle core event pulses in N_COUNTERS counters, each COUNTER_WIDTH bits wide.
- Holds the PMU control and overflow-status registers.
- Serves the slave's zero-latency read port (8-bit address in, 64-bit data out) and accepts a simple write port for configuration and counter preload.

---
 rtl/pmu_counter_bank.sv | 112 +++++++++++
 tb/tb_pmu_counter_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pmu_counter_bank.sv
// rtl/pmu_counter_bank.sv - PMU event-counter bank with CTRL/OVF registers and zero-latency read port
module pmu_counter_bank #(
  parameter int N_COUNTERS    = 23,
  parameter int COUNTER_WIDTH = 64,
  parameter int DATA_WIDTH    = 64
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESET,
  input  logic [N_COUNTERS-1:0]   events_i,
  input  logic [7:0]              counter_address_in,
  output logic [DATA_WIDTH-1:0]   counter_data_out,
  input  logic                    cfg_we_i,
  input  logic [7:0]              cfg_addr_i,
  input  logic [DATA_WIDTH-1:0]   cfg_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cfg_wstrb_i,
  output logic                    pmu_enabled_o,
  output logic                    overflow_irq_o
);

  localparam logic [7:0] CTRL_IDX = 8'(N_COUNTERS);
  localparam logic [7:0] OVF_IDX  = 8'(N_COUNTERS + 1);

  logic [COUNTER_WIDTH-1:0] r_cnt [N_COUNTERS];
  logic [N_COUNTERS-1:0]    r_ovf;
  logic                     r_en;
  logic                     r_clr;
  logic                     r_freeze;

  logic [DATA_WIDTH-1:0]    w_wmask;
  logic                     w_ctrl_we;
  logic                     w_ovf_we;
  logic [N_COUNTERS-1:0]    w_ovf_w1c;
  logic [N_COUNTERS-1:0]    w_ovf_set;
  logic [COUNTER_WIDTH-1:0] w_cnt_nxt [N_COUNTERS];

  assign w_ctrl_we = cfg_we_i && (cfg_addr_i == CTRL_IDX) && cfg_wstrb_i[0];
  assign w_ovf_we  = cfg_we_i && (cfg_addr_i == OVF_IDX);

  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      w_wmask[b*8 +: 8] = {8{cfg_wstrb_i[b]}};
    end
  end

  always_comb begin
    w_ovf_w1c = '0;
    for (int k = 0; k < N_COUNTERS; k++) begin
      w_ovf_w1c[k] = w_ovf_we && cfg_wdata_i[k] && cfg_wstrb_i[k/8];
    end
  end

  // Preload outranks counting, so an event landing on a preload cycle is dropped.
  always_comb begin
    w_ovf_set = '0;
    for (int k = 0; k < N_COUNTERS; k++) begin
      w_cnt_nxt[k] = r_cnt[k];
      if (cfg_we_i && (cfg_addr_i == 8'(k))) begin
        w_cnt_nxt[k] = (r_cnt[k] & ~w_wmask) | (cfg_wdata_i & w_wmask);
      end else if (r_en && events_i[k]) begin
        if (&r_cnt[k]) begin
          w_ovf_set[k] = 1'b1;
          if (!r_freeze) w_cnt_nxt[k] = '0;
        end else begin
          w_cnt_nxt[k] = r_cnt[k] + COUNTER_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_en     <= 1'b0;
      r_clr    <= 1'b0;
      r_freeze <= 1'b0;
      r_ovf    <= '0;
      for (int k = 0; k < N_COUNTERS; k++) r_cnt[k] <= '0;
    end else begin
      // A pending CLR wipes counters and flags, then drops itself.
      if (r_clr) begin
        r_clr <= 1'b0;
        r_ovf <= '0;
        for (int k = 0; k < N_COUNTERS; k++) r_cnt[k] <= '0;
      end else begin
        r_clr <= w_ctrl_we && cfg_wdata_i[1];
        r_ovf <= (r_ovf & ~w_ovf_w1c) | w_ovf_set;
        for (int k = 0; k < N_COUNTERS; k++) r_cnt[k] <= w_cnt_nxt[k];
      end
      if (w_ctrl_we) begin
        r_en     <= cfg_wdata_i[0];
        r_freeze <= cfg_wdata_i[2];
      end
    end
  end

  always_comb begin
    counter_data_out = '0;
    for (int k = 0; k < N_COUNTERS; k++) begin
      if (counter_address_in == 8'(k)) counter_data_out = r_cnt[k];
    end
    if (counter_address_in == CTRL_IDX) begin
      counter_data_out = {{(DATA_WIDTH-3){1'b0}}, r_freeze, r_clr, r_en};
    end
    if (counter_address_in == OVF_IDX) begin
      counter_data_out = {{(DATA_WIDTH-N_COUNTERS){1'b0}}, r_ovf};
    end
  end

  assign pmu_enabled_o  = r_en;
  assign overflow_irq_o = |r_ovf;

endmodule

// File: tb/tb_pmu_counter_bank.sv
// tb/tb_pmu_counter_bank.sv - scoreboard bench for pmu_counter_bank
module tb_pmu_counter_bank;

  logic        clk;
  logic        rst;
  logic [22:0] events_i;
  logic [7:0]  counter_address_in;
  logic [63:0] counter_data_out;
  logic        cfg_we_i;
  logic [7:0]  cfg_addr_i;
  logic [63:0] cfg_wdata_i;
  logic [7:0]  cfg_wstrb_i;
  logic        pmu_enabled_o;
  logic        overflow_irq_o;

  pmu_counter_bank dut (
    .S_AXI_ACLK         (clk),
    .S_AXI_ARESET       (rst),
    .events_i           (events_i),
    .counter_address_in (counter_address_in),
    .counter_data_out   (counter_data_out),
    .cfg_we_i           (cfg_we_i),
    .cfg_addr_i         (cfg_addr_i),
    .cfg_wdata_i        (cfg_wdata_i),
    .cfg_wstrb_i        (cfg_wstrb_i),
    .pmu_enabled_o      (pmu_enabled_o),
    .overflow_irq_o     (overflow_irq_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          q_kind [$];
  logic [63:0] q_exp  [$];
  string       q_name [$];

  // kind 0: read data, 1: pmu_enabled_o, 2: overflow_irq_o
  initial begin
    forever begin
      @(negedge clk);
      while (q_kind.size() > 0) begin
        int          kind;
        logic [63:0] exp_v;
        logic [63:0] act_v;
        string       name;
        kind  = q_kind.pop_front();
        exp_v = q_exp.pop_front();
        name  = q_name.pop_front();
        case (kind)
          1:       act_v = {63'd0, pmu_enabled_o};
          2:       act_v = {63'd0, overflow_irq_o};
          default: act_v = counter_data_out;
        endcase
        n_cmp++;
        if (act_v !== exp_v) begin
          n_bad++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", name, act_v, exp_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input logic [7:0] addr, input logic [63:0] v, input string name);
    if (kind == 0) counter_address_in = addr;
    q_kind.push_back(kind);
    q_exp.push_back(v);
    q_name.push_back(name);
  endtask

  task automatic rd(input logic [7:0] addr, input logic [63:0] v, input string name);
    chk(0, addr, v, name);
    tick();
  endtask

  task automatic wr(input logic [7:0] addr, input logic [63:0] data, input logic [7:0] strb);
    cfg_we_i    = 1'b1;
    cfg_addr_i  = addr;
    cfg_wdata_i = data;
    cfg_wstrb_i = strb;
    tick();
    cfg_we_i    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    events_i = '0;
    counter_address_in = '0;
    cfg_we_i = 1'b0;
    cfg_addr_i = '0;
    cfg_wdata_i = '0;
    cfg_wstrb_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk(1, 0, 0, "rst_en");
    chk(2, 0, 0, "rst_irq");
    rd(0, 0, "rst_cnt0");
    rd(23, 0, "rst_ctrl");
    rd(24, 0, "rst_ovf");
    rd(200, 0, "rst_unmapped");

    // basic counting
    wr(23, 64'h1, 8'hFF);
    events_i = '0; events_i[3] = 1'b1; events_i[0] = 1'b1;
    tick();
    events_i[0] = 1'b0;
    repeat (4) tick();
    events_i = '0;
    chk(1, 0, 1, "en_after_ctrl");
    rd(3, 5, "cnt3_five");
    rd(0, 1, "cnt0_one");
    rd(1, 0, "cnt1_zero");

    // wrap with FREEZE=0
    wr(7, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    events_i[7] = 1'b1;
    repeat (3) tick();
    events_i = '0;
    chk(2, 0, 1, "irq_after_wrap");
    rd(7, 1, "cnt7_wrapped");
    rd(24, 64'h80, "ovf_after_wrap");
    wr(24, 64'h80, 8'hFF);
    chk(2, 0, 0, "irq_after_w1c");
    rd(24, 0, "ovf_after_w1c");

    // saturate with FREEZE=1, W1C racing a new overflow
    wr(23, 64'h5, 8'hFF);
    wr(7, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    events_i[7] = 1'b1;
    repeat (3) tick();
    wr(24, 64'h80, 8'hFF);
    events_i = '0;
    chk(2, 0, 1, "irq_set_wins");
    rd(24, 64'h80, "ovf_set_wins");
    rd(7, 64'hFFFF_FFFF_FFFF_FFFF, "cnt7_frozen");
    wr(8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    rd(8, 64'hFFFF_FFFF_FFFF_FFFF, "cnt8_preload_ones");
    rd(24, 64'h80, "ovf_preload_no_set");

    // CLR: pending for one cycle, then clears everything
    wr(23, 64'h0, 8'hFF);
    wr(2, 64'h10, 8'hFF);
    events_i[2] = 1'b1;
    wr(23, 64'h3, 8'hFF);
    chk(2, 0, 1, "irq_before_clr");
    rd(23, 64'h3, "ctrl_clr_pending");
    events_i = '0;
    chk(2, 0, 0, "irq_after_clr");
    rd(2, 0, "cnt2_cleared");
    rd(24, 0, "ovf_cleared");
    rd(7, 0, "cnt7_cleared");
    rd(23, 64'h1, "ctrl_clr_selfclear");
    events_i[2] = 1'b1;
    tick();
    events_i = '0;
    rd(2, 1, "cnt2_resumed");

    // byte strobes, then asynchronous reset
    wr(5, 64'h1234, 8'hFF);
    wr(5, 64'hAB, 8'h01);
    rd(5, 64'h12AB, "cnt5_strobe_merge");
    rst = 1'b1;
    #1;
    chk(0, 5, 0, "async_rst_cnt5");
    chk(1, 0, 0, "async_rst_en");
    @(negedge clk);
    #1 rst = 1'b0;
    tick();
    rd(23, 0, "post_rst_ctrl");
    rd(2, 0, "post_rst_cnt2");

    repeat (2) tick();
    if (q_kind.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d checks pending, expected 0", q_kind.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
